// File: rtl/psum_wb_drain_if.sv
// Write-back stream bundle for the psum drain engine: valid/ready with data and
// an end-of-run marker.
interface psum_wb_drain_if #(
    parameter int BIT_WB = 8
);
    logic              o_Valid_WB;
    logic [BIT_WB-1:0] o_Data_WB;
    logic              o_Last_WB;
    logic              i_ready;

    modport master (
        output o_Valid_WB,
        output o_Data_WB,
        output o_Last_WB,
        input  i_ready
    );

    modport slave (
        input  o_Valid_WB,
        input  o_Data_WB,
        input  o_Last_WB,
        output i_ready
    );
endinterface

// File: rtl/psum_wb_drain.sv
// Psum write-back drain: reads rows from the NUM_COL psum banks, post-processes
// each word (saturate / ReLU / rounded shift) and serialises them on a stream.
module psum_wb_drain #(
    parameter int NUM_COL  = 8,
    parameter int BIT_ADDR = 10,
    parameter int BIT_PSUM = 32,
    parameter int BIT_WB   = 8
) (
    input  logic                         CLK,
    input  logic                         RSTb,
    input  logic                         i_start,
    input  logic [BIT_ADDR-1:0]          i_base_addr,
    input  logic [BIT_ADDR:0]            i_len,
    input  logic [1:0]                   i_mode,
    input  logic [4:0]                   i_shift,
    input  logic                         i_abort,
    input  logic [NUM_COL*BIT_PSUM-1:0]  sram_psum_dout_b,
    output logic [NUM_COL-1:0]           sram_psum_en_b,
    output logic [NUM_COL-1:0]           sram_psum_we_b,
    output logic [NUM_COL*BIT_ADDR-1:0]  sram_psum_addr_b,
    psum_wb_drain_if.master              wb,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int COL_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COL - 1);
    localparam logic [BIT_ADDR:0] ONE_ROW = (BIT_ADDR+1)'(1);

    localparam logic signed [BIT_PSUM:0] EXT_ONE = (BIT_PSUM+1)'(1);
    localparam logic signed [BIT_PSUM:0] WB_MAX  = (EXT_ONE << (BIT_WB - 1)) - EXT_ONE;
    localparam logic signed [BIT_PSUM:0] WB_MIN  = ~WB_MAX;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SEND
    } state_e;

    state_e                          state_q, state_d;
    logic [BIT_ADDR-1:0]             addr_q, addr_d;
    logic [BIT_ADDR:0]               rows_left_q, rows_left_d;
    logic [1:0]                      mode_q, mode_d;
    logic [4:0]                      shift_q, shift_d;
    logic [COL_W-1:0]                col_q, col_d;
    logic [NUM_COL-1:0][BIT_WB-1:0]  row_q, row_d;
    logic                            valid_q, valid_d;
    logic [BIT_WB-1:0]               data_q, data_d;
    logic                            last_q, last_d;
    logic                            en_q, en_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    logic [NUM_COL-1:0][BIT_WB-1:0]  row_proc;
    logic [COL_W-1:0]                col_nxt;
    logic                            final_row;

    // Evaluated one bit wider than the psum so the rounding add cannot overflow.
    function automatic logic [BIT_WB-1:0] post_proc(
        input logic [BIT_PSUM-1:0] raw,
        input logic [1:0]          mode,
        input logic [4:0]          sh
    );
        logic signed [BIT_PSUM:0] x;
        logic signed [BIT_PSUM:0] y;
        logic signed [BIT_PSUM:0] rnd;
        x   = $signed({raw[BIT_PSUM-1], raw});
        y   = x;
        rnd = '0;
        if (mode == 2'd2 && sh != '0) begin
            rnd = EXT_ONE << (sh - 5'd1);
            y   = (x + rnd) >>> sh;
        end
        if ((mode == 2'd1 || mode == 2'd2) && y[BIT_PSUM]) begin
            y = '0;
        end
        if (y > WB_MAX) begin
            y = WB_MAX;
        end else if (y < WB_MIN) begin
            y = WB_MIN;
        end
        return y[BIT_WB-1:0];
    endfunction

    always_comb begin
        row_proc = '0;
        for (int unsigned c = 0; c < NUM_COL; c++) begin
            row_proc[c] = post_proc(sram_psum_dout_b[c*BIT_PSUM +: BIT_PSUM], mode_q, shift_q);
        end
    end

    assign col_nxt   = col_q + 1'b1;
    assign final_row = (rows_left_q == ONE_ROW);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rows_left_d = rows_left_q;
        mode_d      = mode_q;
        shift_d     = shift_q;
        col_d       = col_q;
        row_d       = row_q;
        valid_d     = valid_q;
        data_d      = data_q;
        last_d      = last_q;
        en_d        = en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (i_abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            col_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        mode_d  = i_mode;
                        shift_d = i_shift;
                        if (i_len != '0) begin
                            state_d     = ST_READ;
                            addr_d      = i_base_addr;
                            rows_left_d = i_len;
                            en_d        = 1'b1;
                            busy_d      = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    en_d    = 1'b0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    row_d   = row_proc;
                    col_d   = '0;
                    valid_d = 1'b1;
                    data_d  = row_proc[0];
                    last_d  = final_row && (NUM_COL == 1);
                    state_d = ST_SEND;
                end
                ST_SEND: begin
                    if (valid_q && wb.i_ready) begin
                        if (col_q != LAST_COL) begin
                            col_d  = col_nxt;
                            data_d = row_q[col_nxt];
                            last_d = final_row && (col_nxt == LAST_COL);
                        end else begin
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            if (!final_row) begin
                                addr_d      = addr_q + 1'b1;
                                rows_left_d = rows_left_q - ONE_ROW;
                                en_d        = 1'b1;
                                state_d     = ST_READ;
                            end else begin
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rows_left_q <= '0;
            mode_q      <= '0;
            shift_q     <= '0;
            col_q       <= '0;
            row_q       <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            last_q      <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rows_left_q <= rows_left_d;
            mode_q      <= mode_d;
            shift_q     <= shift_d;
            col_q       <= col_d;
            row_q       <= row_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            last_q      <= last_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sram_psum_en_b   = {NUM_COL{en_q}};
    assign sram_psum_we_b   = '0;
    assign sram_psum_addr_b = {NUM_COL{addr_q}};
    assign wb.o_Valid_WB    = valid_q;
    assign wb.o_Data_WB     = data_q;
    assign wb.o_Last_WB     = last_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;

endmodule

// File: tb/tb_psum_wb_drain.sv
// Randomised bench for psum_wb_drain: SRAM bank model, reference post-processing
// model and a scoreboard on the write-back stream and the SRAM read addresses.
module tb_psum_wb_drain;

    localparam int NC = 4;
    localparam int BA = 10;
    localparam int BP = 32;
    localparam int BW = 8;

    logic              CLK = 1'b0;
    logic              RSTb = 1'b0;
    logic              i_start = 1'b0;
    logic [BA-1:0]     i_base_addr = '0;
    logic [BA:0]       i_len = '0;
    logic [1:0]        i_mode = '0;
    logic [4:0]        i_shift = '0;
    logic              i_abort = 1'b0;
    logic [NC*BP-1:0]  sram_psum_dout_b = '0;
    logic [NC-1:0]     sram_psum_en_b;
    logic [NC-1:0]     sram_psum_we_b;
    logic [NC*BA-1:0]  sram_psum_addr_b;
    logic              o_busy;
    logic              o_done;

    psum_wb_drain_if #(.BIT_WB(BW)) wb_if ();

    psum_wb_drain #(
        .NUM_COL (NC),
        .BIT_ADDR(BA),
        .BIT_PSUM(BP),
        .BIT_WB  (BW)
    ) dut (
        .CLK             (CLK),
        .RSTb            (RSTb),
        .i_start         (i_start),
        .i_base_addr     (i_base_addr),
        .i_len           (i_len),
        .i_mode          (i_mode),
        .i_shift         (i_shift),
        .i_abort         (i_abort),
        .sram_psum_dout_b(sram_psum_dout_b),
        .sram_psum_en_b  (sram_psum_en_b),
        .sram_psum_we_b  (sram_psum_we_b),
        .sram_psum_addr_b(sram_psum_addr_b),
        .wb              (wb_if),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 CLK = ~CLK;

    logic signed [BP-1:0] mem [NC][1<<BA];

    always @(posedge CLK) begin
        for (int b = 0; b < NC; b++) begin
            if (sram_psum_en_b[b]) begin
                sram_psum_dout_b[b*BP +: BP] <= mem[b][sram_psum_addr_b[b*BA +: BA]];
            end
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: round-half-up division by 2^s done with floor division on longints.
    function automatic logic [BW-1:0] ref_wb(input logic signed [BP-1:0] raw,
                                             input logic [1:0] mode, input logic [4:0] sh);
        longint x;
        longint y;
        longint d;
        longint hi;
        longint lo;
        x  = raw;
        y  = x;
        hi = (longint'(1) << (BW - 1)) - 1;
        lo = -(longint'(1) << (BW - 1));
        if (mode == 2'd2 && sh != 0) begin
            d = longint'(1) << sh;
            y = x + d / 2;
            if (y >= 0) y = y / d;
            else        y = -((-y + d - 1) / d);
        end
        if ((mode == 2'd1 || mode == 2'd2) && y < 0) y = 0;
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        return y[BW-1:0];
    endfunction

    logic [BW-1:0] exp_q[$];
    logic [BA-1:0] exp_addr_q[$];
    int            xfer_cyc[$];
    int            n_xfer = 0;
    int            n_done = 0;
    int            ready_pat = 0;
    bit            stall_chk_en = 1'b1;

    initial begin : ready_drv
        int phase;
        phase = 0;
        wb_if.i_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_pat)
                0: wb_if.i_ready = 1'b1;
                1: begin
                    wb_if.i_ready = (phase == 0 || phase == 3);
                    phase = (phase + 1) % 4;
                end
                default: wb_if.i_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        bit            prev_stall;
        logic [BW-1:0] prev_data;
        logic          prev_last;
        logic [BW-1:0] e;
        logic [BA-1:0] a;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RSTb) begin
                prev_stall = 1'b0;
            end else begin
                if (sram_psum_en_b != '0) begin
                    chk("en_all_banks", sram_psum_en_b, {NC{1'b1}});
                    chk("we_zero", sram_psum_we_b, 0);
                    if (exp_addr_q.size() == 0) begin
                        chk("unexpected_read", 1, 0);
                    end else begin
                        a = exp_addr_q.pop_front();
                        chk("rd_addr", sram_psum_addr_b, {NC{a}});
                    end
                end
                if (stall_chk_en && prev_stall) begin
                    chk("stall_valid", wb_if.o_Valid_WB, 1);
                    chk("stall_data", wb_if.o_Data_WB, prev_data);
                    chk("stall_last", wb_if.o_Last_WB, prev_last);
                end
                if (wb_if.o_Valid_WB && wb_if.i_ready && !i_abort) begin
                    n_xfer++;
                    xfer_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", wb_if.o_Data_WB, e);
                        chk("last", wb_if.o_Last_WB, exp_q.size() == 0);
                    end
                end
                prev_stall = wb_if.o_Valid_WB && !wb_if.i_ready && !i_abort;
                prev_data  = wb_if.o_Data_WB;
                prev_last  = wb_if.o_Last_WB;
                if (o_done) n_done++;
            end
        end
    end

    int start_cyc = 0;
    int done_cyc  = 0;

    task automatic do_start(input logic [BA-1:0] base, input int len,
                            input logic [1:0] mode, input logic [4:0] sh);
        @(posedge CLK);
        #1;
        i_start     = 1'b1;
        i_base_addr = base;
        i_len       = (BA+1)'(len);
        i_mode      = mode;
        i_shift     = sh;
        @(posedge CLK);
        #1;
        start_cyc   = cyc;
        i_start     = 1'b0;
        i_base_addr = BA'($urandom);
        i_len       = (BA+1)'($urandom);
        i_mode      = 2'($urandom);
        i_shift     = 5'($urandom);
    endtask

    task automatic run(input logic [BA-1:0] base, input int len, input logic [1:0] mode,
                       input logic [4:0] sh, input int rp, input bit prefilled);
        int t;
        ready_pat = rp;
        xfer_cyc.delete();
        if (!prefilled) begin
            for (int r = 0; r < len; r++)
                for (int c = 0; c < NC; c++)
                    exp_q.push_back(ref_wb(mem[c][BA'(int'(base) + r)], mode, sh));
        end
        for (int r = 0; r < len; r++) exp_addr_q.push_back(BA'(int'(base) + r));
        do_start(base, len, mode, sh);
        @(negedge CLK);
        t = 0;
        while (!o_done && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        done_cyc = cyc;
        chk("done_seen", o_done, 1);
        chk("busy_at_done", o_busy, 0);
        chk("words_left", exp_q.size(), 0);
        chk("reads_left", exp_addr_q.size(), 0);
        if (len == 0) chk("zero_len_done_cyc", done_cyc - start_cyc, 0);
        @(negedge CLK);
        chk("done_pulse_width", o_done, 0);
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic arith(input logic [1:0] mode, input logic [4:0] sh,
                         input int v0, input int v1, input int v2, input int v3,
                         input int e0, input int e1, input int e2, input int e3);
        mem[0][200] = v0; mem[1][200] = v1; mem[2][200] = v2; mem[3][200] = v3;
        exp_q.push_back(BW'(e0)); exp_q.push_back(BW'(e1));
        exp_q.push_back(BW'(e2)); exp_q.push_back(BW'(e3));
        run(10'd200, 1, mode, sh, 0, 1'b1);
    endtask

    task automatic wait_xfers(input int n0, input int k);
        int t;
        t = 0;
        while (n_xfer - n0 < k && t < 200) begin
            @(posedge CLK);
            #1;
            t++;
        end
        chk("wait_xfers", n_xfer - n0, k);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, wb_if.o_Valid_WB, 0);
        chk({tag, "_data"}, wb_if.o_Data_WB, 0);
        chk({tag, "_last"}, wb_if.o_Last_WB, 0);
        chk({tag, "_en"}, sram_psum_en_b, 0);
        chk({tag, "_addr"}, sram_psum_addr_b, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n0;
        int d0;
        for (int b = 0; b < NC; b++)
            for (int a = 0; a < (1 << BA); a++) mem[b][a] = '0;
        for (int c = 0; c < NC; c++) begin
            mem[c][10] = c + 1;
            mem[c][11] = c + 5;
        end

        #12;
        check_all_zero("reset");
        @(posedge CLK);
        #1;
        RSTb = 1'b1;

        run(10'd10, 2, 2'd0, 5'd0, 0, 1'b0);
        chk("basic_nxfer", xfer_cyc.size(), 8);
        if (xfer_cyc.size() == 8) begin
            chk("basic_first_latency", xfer_cyc[0] - start_cyc, 2);
            chk("basic_row_gap", xfer_cyc[4] - xfer_cyc[3], 3);
            chk("basic_in_row", xfer_cyc[3] - xfer_cyc[0], 3);
            chk("basic_done_after_last", done_cyc - xfer_cyc[7], 1);
        end

        n0 = n_xfer;
        run(10'd10, 2, 2'd0, 5'd0, 1, 1'b0);
        chk("bp_nxfer", n_xfer - n0, 8);

        arith(2'd0, 5'd0, 300, -300, -5, 7, 127, -128, -5, 7);
        arith(2'd1, 5'd0, -5, 300, 0, 127, 0, 127, 0, 127);
        arith(2'd2, 5'd2, 10, -10, 6, -300, 3, 0, 2, 0);
        arith(2'd2, 5'd1, 7, -7, 1, 1000, 4, 0, 1, 127);
        arith(2'd2, 5'd0, 50, -50, 200, 0, 50, 0, 127, 0);
        arith(2'd3, 5'd3, 300, -1, -300, 9, 127, -1, -128, 9);

        for (int c = 0; c < NC; c++) begin
            mem[c][1023] = 20 + c;
            mem[c][0]    = -20 - c;
        end
        run(10'd1023, 2, 2'd0, 5'd0, 0, 1'b0);

        n0 = n_xfer;
        run(10'd50, 0, 2'd0, 5'd0, 0, 1'b0);
        chk("zero_len_nxfer", n_xfer - n0, 0);

        ready_pat = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NC; c++) exp_q.push_back(ref_wb(mem[c][10 + r], 2'd0, 5'd0));
        exp_addr_q.push_back(10'd10);
        n0 = n_xfer;
        d0 = n_done;
        do_start(10'd10, 2, 2'd0, 5'd0);
        wait_xfers(n0, 2);
        chk("abort_pre_valid", wb_if.o_Valid_WB, 1);
        chk("abort_pre_busy", o_busy, 1);
        i_abort = 1'b1;
        @(posedge CLK);
        #1;
        i_abort = 1'b0;
        chk("abort_valid", wb_if.o_Valid_WB, 0);
        chk("abort_last", wb_if.o_Last_WB, 0);
        chk("abort_en", sram_psum_en_b, 0);
        chk("abort_busy", o_busy, 0);
        exp_q.delete();
        exp_addr_q.delete();
        repeat (20) @(negedge CLK);
        chk("abort_no_done", n_done - d0, 0);
        chk("abort_nxfer", n_xfer - n0, 2);
        run(10'd10, 2, 2'd0, 5'd0, 0, 1'b0);

        for (int r = 0; r < 3; r++)
            for (int c = 0; c < NC; c++) exp_q.push_back(ref_wb(mem[c][10 + r], 2'd1, 5'd0));
        for (int r = 0; r < 3; r++) exp_addr_q.push_back(BA'(10 + r));
        n0 = n_xfer;
        do_start(10'd10, 3, 2'd1, 5'd0);
        wait_xfers(n0, 2);
        #2;
        stall_chk_en = 1'b0;
        RSTb = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        exp_addr_q.delete();
        @(posedge CLK);
        #1;
        RSTb = 1'b1;
        stall_chk_en = 1'b1;
        n0 = n_xfer;
        run(10'd10, 2, 2'd0, 5'd0, 0, 1'b0);
        chk("post_reset_nxfer", n_xfer - n0, 8);

        for (int k = 0; k < 10; k++) begin
            logic [BA-1:0] base;
            int            len;
            base = BA'($urandom);
            len  = (k == 3) ? 0 : int'($urandom_range(1, 5));
            for (int r = 0; r < len; r++)
                for (int c = 0; c < NC; c++)
                    mem[c][BA'(int'(base) + r)] = ($urandom_range(0, 1) == 0)
                        ? BP'(int'($urandom_range(0, 600)) - 300) : BP'($urandom);
            run(base, len, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 9)), 2, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
